// File: rtl/tcp_rx_notify_splitter_if.sv
// Valid/ready descriptor channel carrying a session ID and a byte length.
// Used for both the notification input and the read-descriptor output.
interface tcp_rx_notify_splitter_if #(
  parameter int SID_BITS = 16,
  parameter int LEN_BITS = 16
);
  logic                valid;
  logic                ready;
  logic [SID_BITS-1:0] sid;
  logic [LEN_BITS-1:0] len;

  modport master (
    output valid,
    output sid,
    output len,
    input  ready
  );

  modport slave (
    input  valid,
    input  sid,
    input  len,
    output ready
  );
endinterface

// File: rtl/tcp_rx_notify_splitter.sv
// Splits TCP RX notifications into read descriptors of at most MAX_CHUNK bytes.
// A credit counter bounds in-flight descriptors; s_cmpl returns one credit.
module tcp_rx_notify_splitter #(
  parameter  int SID_BITS      = 16,
  parameter  int LEN_BITS      = 16,
  parameter  int MAX_CHUNK     = 4096,
  parameter  int N_OUTSTANDING = 8,
  localparam int CRED_W        = $clog2(N_OUTSTANDING + 1)
) (
  input  logic                     aclk,
  input  logic                     areset,
  tcp_rx_notify_splitter_if.slave  s_notify,
  tcp_rx_notify_splitter_if.master m_rd_pkg,
  input  logic                     s_cmpl,
  output logic [CRED_W-1:0]        credits,
  output logic                     busy,
  output logic                     err_cmpl_ovf
);

  localparam logic [LEN_BITS-1:0] CHUNK_MAX = LEN_BITS'(MAX_CHUNK);
  localparam logic [CRED_W-1:0]   CRED_FULL = CRED_W'(N_OUTSTANDING);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  function automatic logic [LEN_BITS-1:0] sat_chunk(input logic [LEN_BITS-1:0] rem);
    return (rem > CHUNK_MAX) ? CHUNK_MAX : rem;
  endfunction

  state_t              state_r, state_nxt;
  logic [SID_BITS-1:0] sid_r, sid_nxt;
  logic [LEN_BITS-1:0] rem_r, rem_nxt;
  logic [CRED_W-1:0]   cred_r, cred_nxt;
  logic                err_r, err_nxt;

  logic [LEN_BITS-1:0] chunk;
  logic                full;
  logic                notify_ready;
  logic                pkg_valid;
  logic                accept;
  logic                fire;
  logic                cred_ret;

  // Every output is a function of registered state only.
  assign chunk        = sat_chunk(rem_r);
  assign full         = (cred_r == CRED_FULL);
  assign notify_ready = (state_r == ST_IDLE);
  assign pkg_valid    = (state_r == ST_ISSUE) && (cred_r != '0);
  assign accept       = s_notify.valid & notify_ready;
  assign fire         = pkg_valid & m_rd_pkg.ready;
  assign cred_ret     = s_cmpl & ~full;

  assign s_notify.ready = notify_ready;
  assign m_rd_pkg.valid = pkg_valid;
  assign m_rd_pkg.sid   = sid_r;
  assign m_rd_pkg.len   = chunk;
  assign credits        = cred_r;
  assign busy           = (state_r == ST_ISSUE);
  assign err_cmpl_ovf   = err_r;

  always_comb begin
    state_nxt = state_r;
    sid_nxt   = sid_r;
    rem_nxt   = rem_r;
    cred_nxt  = cred_r;
    err_nxt   = err_r | (s_cmpl & full);

    case (state_r)
      ST_IDLE: begin
        if (accept) begin
          sid_nxt = s_notify.sid;
          rem_nxt = s_notify.len;
          // A zero-length notification is consumed without issuing anything.
          if (s_notify.len != '0) state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (fire) begin
          rem_nxt = rem_r - chunk;
          if (rem_r == chunk) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    case ({fire, cred_ret})
      2'b10:   cred_nxt = cred_r - CRED_W'(1);
      2'b01:   cred_nxt = cred_r + CRED_W'(1);
      default: cred_nxt = cred_r;
    endcase
  end

  // Reset restores full credit: downstream stages are reset alongside this block.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r <= ST_IDLE;
      sid_r   <= '0;
      rem_r   <= '0;
      cred_r  <= CRED_FULL;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      sid_r   <= sid_nxt;
      rem_r   <= rem_nxt;
      cred_r  <= cred_nxt;
      err_r   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_tcp_rx_notify_splitter.sv
// Directed bench for tcp_rx_notify_splitter: a queue-based transaction model
// checked every cycle, plus hand-computed literal expectations.
module tb_tcp_rx_notify_splitter;

  localparam int SID_BITS = 16;
  localparam int LEN_BITS = 16;
  localparam int MAXC     = 4096;
  localparam int NOUT     = 8;
  localparam int CRED_W   = $clog2(NOUT + 1);

  typedef struct {
    logic [SID_BITS-1:0] sid;
    logic [LEN_BITS-1:0] len;
  } desc_t;

  logic              clk = 1'b0;
  logic              areset = 1'b1;
  logic              s_cmpl = 1'b0;
  logic [CRED_W-1:0] credits;
  logic              busy;
  logic              err_cmpl_ovf;

  tcp_rx_notify_splitter_if #(.SID_BITS(SID_BITS), .LEN_BITS(LEN_BITS)) ntf();
  tcp_rx_notify_splitter_if #(.SID_BITS(SID_BITS), .LEN_BITS(LEN_BITS)) rd();

  tcp_rx_notify_splitter #(
    .SID_BITS(SID_BITS), .LEN_BITS(LEN_BITS), .MAX_CHUNK(MAXC), .N_OUTSTANDING(NOUT)
  ) dut (
    .aclk(clk), .areset(areset), .s_notify(ntf), .m_rd_pkg(rd),
    .s_cmpl(s_cmpl), .credits(credits), .busy(busy), .err_cmpl_ovf(err_cmpl_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Transaction model: pending descriptors, free credits, sticky error.
  desc_t exp_q[$];
  desc_t fire_log[$];
  int    m_cred   = NOUT;
  bit    m_err    = 1'b0;
  bit    model_ok = 1'b0;

  always @(negedge clk) begin
    bit    exp_valid;
    bit    m_fire;
    int    r;
    desc_t d;
    exp_valid = (exp_q.size() != 0) && (m_cred > 0);
    if (model_ok) begin
      chk("m_ready",   32'(ntf.ready),    32'(exp_q.size() == 0));
      chk("m_valid",   32'(rd.valid),     32'(exp_valid));
      chk("m_busy",    32'(busy),         32'(exp_q.size() != 0));
      chk("m_credits", 32'(credits),      32'(m_cred));
      chk("m_err",     32'(err_cmpl_ovf), 32'(m_err));
      if (exp_valid) begin
        chk("m_sid", 32'(rd.sid), 32'(exp_q[0].sid));
        chk("m_len", 32'(rd.len), 32'(exp_q[0].len));
      end
    end
    if (!areset && rd.valid && rd.ready) begin
      d.sid = rd.sid;
      d.len = rd.len;
      fire_log.push_back(d);
    end
    if (areset) begin
      exp_q.delete();
      m_cred   = NOUT;
      m_err    = 1'b0;
      model_ok = 1'b1;
    end else begin
      m_fire = exp_valid && rd.ready;
      if (m_fire) void'(exp_q.pop_front());
      if (exp_q.size() == 0 && !m_fire && ntf.valid) begin
        r = int'(ntf.len);
        while (r > 0) begin
          d.sid = ntf.sid;
          d.len = LEN_BITS'((r > MAXC) ? MAXC : r);
          exp_q.push_back(d);
          r -= (r > MAXC) ? MAXC : r;
        end
      end
      if (s_cmpl && m_cred == NOUT) m_err = 1'b1;
      m_cred = m_cred - int'(m_fire) + int'(s_cmpl && m_cred != NOUT);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic notify(input int sid, input int len);
    for (int i = 0; i < 200 && !ntf.ready; i++) tick();
    chk("notify_ready", 32'(ntf.ready), 32'd1);
    ntf.valid = 1'b1;
    ntf.sid   = SID_BITS'(sid);
    ntf.len   = LEN_BITS'(len);
    tick();
    ntf.valid = 1'b0;
  endtask

  task automatic cmpl(input int n);
    for (int i = 0; i < n; i++) begin
      s_cmpl = 1'b1;
      tick();
      s_cmpl = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ntf.valid = 1'b0;
    ntf.sid   = '0;
    ntf.len   = '0;
    rd.ready  = 1'b1;
    tick();
    tick();
    areset = 1'b0;

    // Reset state
    chk("rst_ready",   32'(ntf.ready),    32'd1);
    chk("rst_valid",   32'(rd.valid),     32'd0);
    chk("rst_len",     32'(rd.len),       32'd0);
    chk("rst_sid",     32'(rd.sid),       32'd0);
    chk("rst_credits", 32'(credits),      32'd8);
    chk("rst_busy",    32'(busy),         32'd0);
    chk("rst_err",     32'(err_cmpl_ovf), 32'd0);

    // Single small notification
    notify(5, 100);
    chk("small_valid", 32'(rd.valid),  32'd1);
    chk("small_sid",   32'(rd.sid),    32'd5);
    chk("small_len",   32'(rd.len),    32'd100);
    chk("small_rdy",   32'(ntf.ready), 32'd0);
    tick();
    chk("small_busy",  32'(busy),      32'd0);
    chk("small_cred",  32'(credits),   32'd7);
    cmpl(1);
    chk("small_cred2", 32'(credits),   32'd8);

    // Split 10000 -> 4096, 4096, 1808
    fire_log.delete();
    notify(9, 10000);
    chk("split_rdy0", 32'(ntf.ready), 32'd0);
    tick();
    chk("split_rdy1", 32'(ntf.ready), 32'd0);
    tick();
    chk("split_rdy2", 32'(ntf.ready), 32'd0);
    tick();
    chk("split_rdy3", 32'(ntf.ready), 32'd1);
    chk("split_cnt",  32'(fire_log.size()), 32'd3);
    if (fire_log.size() == 3) begin
      chk("split_l0", 32'(fire_log[0].len), 32'd4096);
      chk("split_l1", 32'(fire_log[1].len), 32'd4096);
      chk("split_l2", 32'(fire_log[2].len), 32'd1808);
      chk("split_sid", 32'(fire_log[2].sid), 32'd9);
    end
    cmpl(3);
    fire_log.delete();
    notify(10, 8192);
    tick();
    tick();
    tick();
    chk("even_cnt", 32'(fire_log.size()), 32'd2);
    if (fire_log.size() == 2) begin
      chk("even_l0", 32'(fire_log[0].len), 32'd4096);
      chk("even_l1", 32'(fire_log[1].len), 32'd4096);
    end
    cmpl(2);
    chk("even_cred", 32'(credits), 32'd8);

    // Credit stall: 40000 bytes = 9 x 4096 + 3136, only 8 credits
    fire_log.delete();
    notify(3, 40000);
    for (int i = 0; i < 12; i++) tick();
    chk("stall_cnt",   32'(fire_log.size()), 32'd8);
    chk("stall_valid", 32'(rd.valid), 32'd0);
    chk("stall_cred",  32'(credits),  32'd0);
    chk("stall_len",   32'(rd.len),   32'd4096);
    chk("stall_busy",  32'(busy),     32'd1);
    cmpl(1);
    chk("stall_rise",  32'(rd.valid), 32'd1);
    // Fire and completion in the same cycle leave credits unchanged
    cmpl(1);
    chk("simul_cred",  32'(credits),  32'd1);
    chk("simul_len",   32'(rd.len),   32'd3136);
    tick();
    chk("stall_done",  32'(ntf.ready), 32'd1);
    chk("stall_cnt2",  32'(fire_log.size()), 32'd10);
    cmpl(8);
    chk("stall_cred2", 32'(credits), 32'd8);
    // Completion while full: ignored, sticky error
    cmpl(1);
    chk("ovf_cred", 32'(credits),      32'd8);
    chk("ovf_err",  32'(err_cmpl_ovf), 32'd1);
    tick();
    tick();
    chk("ovf_sticky", 32'(err_cmpl_ovf), 32'd1);

    // Zero length, then backpressure
    fire_log.delete();
    notify(7, 0);
    chk("zero_rdy",  32'(ntf.ready), 32'd1);
    chk("zero_busy", 32'(busy),      32'd0);
    tick();
    chk("zero_cnt",  32'(fire_log.size()), 32'd0);
    rd.ready = 1'b0;
    notify(8, 5000);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(rd.valid), 32'd1);
      chk("bp_len",   32'(rd.len),   32'd4096);
      tick();
    end
    rd.ready = 1'b1;
    tick();
    tick();
    chk("bp_rdy",  32'(ntf.ready), 32'd1);
    chk("bp_cred", 32'(credits),   32'd6);
    chk("bp_cnt",  32'(fire_log.size()), 32'd2);
    if (fire_log.size() == 2) chk("bp_tail", 32'(fire_log[1].len), 32'd904);
    cmpl(2);

    // Reset mid-operation
    notify(4, 12288);
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("mrst_valid", 32'(rd.valid),     32'd0);
    chk("mrst_rdy",   32'(ntf.ready),    32'd1);
    chk("mrst_cred",  32'(credits),      32'd8);
    chk("mrst_err",   32'(err_cmpl_ovf), 32'd0);
    fire_log.delete();
    notify(11, 64);
    chk("post_sid", 32'(rd.sid), 32'd11);
    chk("post_len", 32'(rd.len), 32'd64);
    tick();
    chk("post_cnt",  32'(fire_log.size()), 32'd1);
    chk("post_cred", 32'(credits), 32'd7);
    cmpl(1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
